// File: rtl/pp_acc_pkg.sv
// Shared types and width helpers for the partial-product row accumulator.
// Optional parity output is enabled in the top by defining PP_ACC_PARITY_EN.
package pp_acc_pkg;

   localparam int unsigned PP_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Product width: the sum of W shifted W-bit rows fits in 2W bits.
   function automatic int unsigned pp_pw(input int unsigned w);
      return 2 * w;
   endfunction

   // Row counter width, never narrower than one bit.
   function automatic int unsigned pp_cw(input int unsigned w);
      return (w > 1) ? int'($clog2(w)) : 1;
   endfunction

   localparam int unsigned PP_PW = pp_pw(PP_W);
   localparam int unsigned PP_CW = pp_cw(PP_W);

endpackage

// File: rtl/pp_shift_adder.sv
// Combinational shift-add step: sum_c = acc + (zero-extended row << shift).
module pp_shift_adder
   import pp_acc_pkg::*;
#(
   parameter int unsigned W  = PP_W,
   parameter int unsigned PW = pp_pw(W),
   parameter int unsigned CW = pp_cw(W)
) (
   input  logic [PW-1:0] acc,
   input  logic [W-1:0]  row,
   input  logic [CW-1:0] shift,
   output logic [PW-1:0] sum_c
);

   logic [PW-1:0] row_ext_c;

   always_comb begin
      row_ext_c = PW'(row);
      sum_c     = acc + (row_ext_c << shift);
   end

endmodule

// File: rtl/pp_row_accumulator.sv
// Sequential shift-add summation of W partial-product rows into a 2W-bit product.
// Define PP_ACC_PARITY_EN to add a registered XOR-reduce of the product (parity).
module pp_row_accumulator
   import pp_acc_pkg::*;
#(
   parameter int unsigned W = PP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W*W-1:0]   pp_rows,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   product,
   output logic             busy
`ifdef PP_ACC_PARITY_EN
  ,output logic             parity
`endif
);

   localparam int unsigned PW = pp_pw(W);
   localparam int unsigned CW = pp_cw(W);

   state_e          state_q;
   state_e          state_d;
   logic [W*W-1:0]  rows_q;
   logic [PW-1:0]   acc_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    row_c;
   logic [PW-1:0]   sum_c;
   logic            last_c;
   logic            load_c;
   logic            step_c;
   logic            capture_c;
   logic            in_ready_d;
   logic            out_valid_d;
   logic            busy_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = ACCUM;
         ACCUM:   if (last_c)    state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Control strobes and next values of the registered status outputs
   always_comb begin
      load_c      = 1'b0;
      step_c      = 1'b0;
      capture_c   = 1'b0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      load_c      = (state_q == IDLE) && in_valid;
      step_c      = (state_q == ACCUM);
      capture_c   = step_c && last_c;
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == ACCUM);
   end

   // Select the row addressed by the counter
   always_comb begin
      row_c = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (cnt_q == CW'(i)) begin
            row_c = rows_q[i*W +: W];
         end
      end
      last_c = (cnt_q == CW'(W - 1));
   end

   pp_shift_adder #(
      .W  (W),
      .PW (PW),
      .CW (CW)
   ) u_shift_adder (
      .acc   (acc_q),
      .row   (row_c),
      .shift (cnt_q),
      .sum_c (sum_c)
   );

   // Operand capture, accumulator and row counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (load_c) begin
         rows_q <= pp_rows;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (step_c) begin
         acc_q  <= sum_c;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

   // Registered handshake/status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

   // Product is captured on the final accumulate edge and held until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         product <= '0;
      end else if (capture_c) begin
         product <= sum_c;
      end
   end

`ifdef PP_ACC_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity <= 1'b0;
      end else if (capture_c) begin
         parity <= ^sum_c;
      end
   end
`endif

endmodule
